// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: spi_top register map,
// CTRL bit positions, sequencer states and the CTRL word builder.
package spi_seq_pkg;

  localparam logic [4:0] ADDR_TX0     = 5'h00;
  localparam logic [4:0] ADDR_RX0     = 5'h00;
  localparam logic [4:0] ADDR_CTRL    = 5'h10;
  localparam logic [4:0] ADDR_DIVIDER = 5'h14;
  localparam logic [4:0] ADDR_SS      = 5'h18;

  localparam int CTRL_GO_BIT     = 8;
  localparam int CTRL_RX_NEG_BIT = 9;
  localparam int CTRL_TX_NEG_BIT = 10;
  localparam int CTRL_LSB_BIT    = 11;
  localparam int CTRL_IE_BIT     = 12;
  localparam int CTRL_ASS_BIT    = 13;

  localparam logic [31:0] CTRL_GO_MASK = 32'h1 << CTRL_GO_BIT;

  typedef enum logic [3:0] {
    IDLE,
    WR_DIV,
    WR_SS,
    WR_TX,
    WR_CTRL,
    WR_GO,
    POLL,
    RD_RX,
    RESP
  } seq_state_e;

  // mode is {lsb, tx_neg, rx_neg}; interrupts stay off, auto slave-select on.
  function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic [2:0] mode);
    logic [31:0] w;
    w                  = '0;
    w[6:0]             = len;
    w[CTRL_RX_NEG_BIT] = mode[0];
    w[CTRL_TX_NEG_BIT] = mode[1];
    w[CTRL_LSB_BIT]    = mode[2];
    w[CTRL_IE_BIT]     = 1'b0;
    w[CTRL_ASS_BIT]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/spi_seq_wb_access.sv
// Single Wishbone read/write access engine. A start pulse launches one access;
// done pulses for one cycle after the ack, with rdata holding the read value.
module spi_seq_wb_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  assign busy = wb_cyc_o;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_sel_o  <= '0;
      wb_data_o <= '0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      if (wb_cyc_o) begin
        // Strobes drop on the ack edge, guaranteeing an idle cycle before the
        // next start can be honoured (start is gated by done upstream).
        if (wb_ack_i) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_sel_o <= '0;
          done     <= 1'b1;
          rdata    <= wb_data_i;
        end
      end else if (start) begin
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= 1'b1;
        wb_we_o   <= we;
        wb_addr_o <= addr;
        wb_data_o <= wdata;
        wb_sel_o  <= 4'hF;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Turns one SPI command into the spi_top register sequence (DIVIDER, SS, TX0,
// CTRL, GO), polls for completion and returns RX0, skipping unchanged config.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         POLL_LIMIT = 4096,
  parameter logic [4:0] RX_ADDR    = 5'h00
) (
  input  logic        wb_clk_in,
  input  logic        wb_rst_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [6:0]  cmd_len,
  input  logic [2:0]  cmd_mode,
  input  logic [31:0] cmd_ss,
  input  logic [15:0] cmd_div,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  seq_state_e state, state_nxt;

  logic [31:0] data_q, ss_q, ss_cache;
  logic [6:0]  len_q;
  logic [2:0]  mode_q;
  logic [15:0] div_q, div_cache;
  logic        div_valid, ss_valid;
  logic [PW-1:0] poll_cnt;

  logic        acc_req, acc_start, acc_we, acc_busy, acc_done;
  logic [4:0]  acc_addr;
  logic [31:0] acc_wdata, acc_rdata, ctrl_q;
  logic        div_miss_in, ss_miss_in, ss_miss_q, poll_busy, poll_timeout;

  assign cmd_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign ctrl_q       = ctrl_word(len_q, mode_q);
  assign div_miss_in  = !div_valid || (cmd_div != div_cache);
  assign ss_miss_in   = !ss_valid || (cmd_ss != ss_cache);
  assign ss_miss_q    = !ss_valid || (ss_q != ss_cache);
  assign poll_busy    = acc_rdata[CTRL_GO_BIT];
  assign poll_timeout = (state == POLL) && acc_done && poll_busy && (poll_cnt == POLL_LAST);
  // done gates start so the engine is not relaunched in the cycle its result is consumed.
  assign acc_start    = acc_req && !acc_busy && !acc_done;

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (div_miss_in)     state_nxt = WR_DIV;
          else if (ss_miss_in) state_nxt = WR_SS;
          else                 state_nxt = WR_TX;
        end
      end
      WR_DIV: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_DIVIDER;
        acc_wdata = {16'h0, div_q};
        if (acc_done) state_nxt = ss_miss_q ? WR_SS : WR_TX;
      end
      WR_SS: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_SS;
        acc_wdata = ss_q;
        if (acc_done) state_nxt = WR_TX;
      end
      WR_TX: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_TX0;
        acc_wdata = data_q;
        if (acc_done) state_nxt = WR_CTRL;
      end
      WR_CTRL: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_CTRL;
        acc_wdata = ctrl_q;
        if (acc_done) state_nxt = WR_GO;
      end
      WR_GO: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_CTRL;
        acc_wdata = ctrl_q | CTRL_GO_MASK;
        if (acc_done) state_nxt = POLL;
      end
      POLL: begin
        acc_req  = 1'b1;
        acc_addr = ADDR_CTRL;
        if (acc_done) begin
          if (!poll_busy)        state_nxt = RD_RX;
          else if (poll_timeout) state_nxt = RESP;
        end
      end
      RD_RX: begin
        acc_req  = 1'b1;
        acc_addr = RX_ADDR;
        if (acc_done) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      data_q    <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      ss_q      <= '0;
      div_q     <= '0;
      ss_cache  <= '0;
      div_cache <= '0;
      div_valid <= 1'b0;
      ss_valid  <= 1'b0;
      poll_cnt  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        data_q   <= cmd_data;
        len_q    <= cmd_len;
        mode_q   <= cmd_mode;
        ss_q     <= cmd_ss;
        div_q    <= cmd_div;
        poll_cnt <= '0;
      end
      if (acc_done) begin
        unique case (state)
          WR_DIV: begin
            div_cache <= div_q;
            div_valid <= 1'b1;
          end
          WR_SS: begin
            ss_cache <= ss_q;
            ss_valid <= 1'b1;
          end
          POLL: begin
            if (poll_busy) poll_cnt <= poll_cnt + 1'b1;
            // A hung transfer leaves spi_top in an unknown state; force a full rewrite.
            if (poll_timeout) begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              div_valid <= 1'b0;
              ss_valid  <= 1'b0;
            end
          end
          RD_RX: begin
            rsp_data <= acc_rdata;
            rsp_err  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  spi_seq_wb_access u_access (
    .clk       (wb_clk_in),
    .rst       (wb_rst_in),
    .start     (acc_start),
    .we        (acc_we),
    .addr      (acc_addr),
    .wdata     (acc_wdata),
    .busy      (acc_busy),
    .done      (acc_done),
    .rdata     (acc_rdata),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_data_o (wb_data_o),
    .wb_data_i (wb_data_i),
    .wb_ack_i  (wb_ack_i)
  );

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer against a behavioural spi_top register
// stub: write ordering, config cache, poll timeout, response hold and reset.
module tb_spi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [6:0]  cmd_len = '0;
  logic [2:0]  cmd_mode = '0;
  logic [31:0] cmd_ss = '0;
  logic [15:0] cmd_div = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [4:0]  wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dout;
  logic [31:0] wb_din = '0;
  logic        wb_ack = 1'b0;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(.POLL_LIMIT(8), .RX_ADDR(5'h00)) dut (
    .wb_clk_in (clk),
    .wb_rst_in (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .cmd_mode  (cmd_mode),
    .cmd_ss    (cmd_ss),
    .cmd_div   (cmd_div),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_we_o   (wb_we),
    .wb_addr_o (wb_addr),
    .wb_sel_o  (wb_sel),
    .wb_data_o (wb_dout),
    .wb_data_i (wb_din),
    .wb_ack_i  (wb_ack)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- spi_top register stub ----------------
  int          ack_wait = 0;
  int          go_polls = 0;
  bit          stuck = 1'b0;
  logic [31:0] rx_value = '0;
  int          wr_n = 0;
  logic [4:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  int          ctrl_reads = 0;
  int          gap_viol = 0, stable_viol = 0, sel_viol = 0;

  initial begin
    int          wait_cnt;
    int          polls_left;
    logic [4:0]  obs_addr;
    logic        obs_we;
    logic [31:0] obs_data;
    wait_cnt   = 0;
    polls_left = 0;
    obs_addr   = '0;
    obs_we     = 1'b0;
    obs_data   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_ack   = 1'b0;
        wait_cnt = 0;
      end else if (wb_ack) begin
        wb_ack = 1'b0;
        if (wb_cyc) gap_viol++;
      end else if (wb_cyc && wb_stb) begin
        if (wait_cnt == 0) begin
          obs_addr = wb_addr;
          obs_we   = wb_we;
          obs_data = wb_dout;
        end else if (wb_addr != obs_addr || wb_we != obs_we || wb_dout != obs_data) begin
          stable_viol++;
        end
        if (wait_cnt >= ack_wait) begin
          wait_cnt = 0;
          wb_ack   = 1'b1;
          if (wb_sel != 4'hF) sel_viol++;
          if (wb_we) begin
            if (wr_n < 16) begin
              wr_addr[wr_n] = wb_addr;
              wr_data[wr_n] = wb_dout;
            end
            wr_n++;
            if (wb_addr == 5'h10 && wb_dout[8]) polls_left = go_polls;
            wb_din = '0;
          end else if (wb_addr == 5'h10) begin
            ctrl_reads++;
            wb_din = 32'h2000 | ((stuck || polls_left > 0) ? 32'h100 : 32'h0);
            if (polls_left > 0) polls_left--;
          end else begin
            wb_din = rx_value;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [4:0]  exp_addr [5];
  logic [31:0] exp_data [5];

  task automatic run_cmd(input logic [31:0] d, input logic [6:0] len, input logic [2:0] mode,
                         input logic [31:0] ss, input logic [15:0] div);
    int guard;
    wr_n       = 0;
    ctrl_reads = 0;
    @(negedge clk);
    cmd_data  = d;
    cmd_len   = len;
    cmd_mode  = mode;
    cmd_ss    = ss;
    cmd_div   = div;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before_accept", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("rsp_valid_arrives", {31'h0, rsp_valid}, 32'h1);
  endtask

  task automatic expect_writes(input string tag, input int n);
    check({tag, "_write_count"}, wr_n, n);
    for (int i = 0; i < n && i < wr_n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), {27'h0, wr_addr[i]}, {27'h0, exp_addr[i]});
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
    end
  endtask

  task automatic consume_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_dropped"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_cmd_ready_back"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    int seen;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_cyc_stb_we", {29'h0, wb_cyc, wb_stb, wb_we}, 32'h0);
    check("reset_addr", {27'h0, wb_addr}, 32'h0);
    check("reset_sel", {28'h0, wb_sel}, 32'h0);
    check("reset_data_o", wb_dout, 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;

    // A: cold cache, full write sequence, three busy polls then done.
    ack_wait = 0; go_polls = 3; stuck = 1'b0; rx_value = 32'h0000_000B;
    run_cmd(32'h2361, 7'd4, 3'b101, 32'h1, 16'h4);
    exp_addr = '{5'h14, 5'h18, 5'h00, 5'h10, 5'h10};
    exp_data = '{32'h4, 32'h1, 32'h2361, 32'h2A04, 32'h2B04};
    expect_writes("A", 5);
    check("A_ctrl_reads", ctrl_reads, 4);
    check("A_rsp_data", rsp_data, 32'hB);
    check("A_rsp_err", {31'h0, rsp_err}, 32'h0);
    consume_rsp("A");

    // B: same div/ss, wait states, response held off for 10 cycles.
    ack_wait = 2; go_polls = 0; rx_value = 32'h0000_005A;
    run_cmd(32'hA5, 7'd8, 3'b000, 32'h1, 16'h4);
    exp_addr = '{5'h00, 5'h10, 5'h10, 5'h00, 5'h00};
    exp_data = '{32'hA5, 32'h2008, 32'h2108, 32'h0, 32'h0};
    expect_writes("B", 3);
    check("B_ctrl_reads", ctrl_reads, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("B_hold_valid%0d", i), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("B_hold_data%0d", i), rsp_data, 32'h5A);
      check($sformatf("B_hold_ready%0d", i), {31'h0, cmd_ready}, 32'h0);
    end
    consume_rsp("B");

    // C: ss change only; GO clears on the 8th read, one short of timeout.
    ack_wait = 0; go_polls = 7; rx_value = 32'h0000_00C3;
    run_cmd(32'h1234, 7'd16, 3'b010, 32'h2, 16'h4);
    exp_addr = '{5'h18, 5'h00, 5'h10, 5'h10, 5'h00};
    exp_data = '{32'h2, 32'h1234, 32'h2410, 32'h2510, 32'h0};
    expect_writes("C", 4);
    check("C_ctrl_reads", ctrl_reads, 8);
    check("C_rsp_data", rsp_data, 32'hC3);
    check("C_rsp_err", {31'h0, rsp_err}, 32'h0);
    consume_rsp("C");

    // D: GO never clears -> timeout after exactly POLL_LIMIT reads.
    stuck = 1'b1; rx_value = 32'h0000_0077;
    run_cmd(32'hFFFF, 7'd4, 3'b101, 32'h2, 16'h4);
    exp_addr = '{5'h00, 5'h10, 5'h10, 5'h00, 5'h00};
    exp_data = '{32'hFFFF, 32'h2A04, 32'h2B04, 32'h0, 32'h0};
    expect_writes("D", 3);
    check("D_ctrl_reads", ctrl_reads, 8);
    check("D_rsp_data", rsp_data, 32'h0);
    check("D_rsp_err", {31'h1, rsp_err} & 32'h1, 32'h1);
    consume_rsp("D");

    // E: cache invalidated by the timeout; len 0 encodes as 0 in CTRL[6:0].
    stuck = 1'b0; go_polls = 1; rx_value = 32'h0000_0099;
    run_cmd(32'h55, 7'd0, 3'b010, 32'h2, 16'h4);
    exp_addr = '{5'h14, 5'h18, 5'h00, 5'h10, 5'h10};
    exp_data = '{32'h4, 32'h2, 32'h55, 32'h2400, 32'h2500};
    expect_writes("E", 5);
    check("E_ctrl_reads", ctrl_reads, 2);
    check("E_rsp_data", rsp_data, 32'h99);
    check("E_rsp_err", {31'h0, rsp_err}, 32'h0);
    consume_rsp("E");

    // F: reset while the TX0 write is waiting for its ack.
    ack_wait = 1000;
    wr_n = 0;
    @(negedge clk);
    cmd_data = 32'hDEAD; cmd_len = 7'd4; cmd_mode = 3'b101; cmd_ss = 32'h2; cmd_div = 16'h4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!wb_cyc && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("F_first_access_is_tx0", {26'h0, wb_cyc, wb_addr}, {26'h0, 1'b1, 5'h00});
    check("F_tx0_data", wb_dout, 32'hDEAD);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("F_cyc_stb_after_reset", {30'h0, wb_cyc, wb_stb}, 32'h0);
    check("F_rsp_valid_in_reset", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    ack_wait = 0;
    @(negedge clk);
    check("F_cmd_ready_after_reset", {31'h0, cmd_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) seen++;
    end
    check("F_no_activity_after_reset", seen, 0);

    // G: reset cleared the cache, so DIVIDER and SS are rewritten.
    go_polls = 0; rx_value = 32'h0000_0042;
    run_cmd(32'h55, 7'd0, 3'b010, 32'h2, 16'h4);
    expect_writes("G", 5);
    check("G_rsp_data", rsp_data, 32'h42);
    consume_rsp("G");

    check("bus_gap_violations", gap_viol, 0);
    check("bus_stability_violations", stable_viol, 0);
    check("bus_sel_violations", sel_viol, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter POLL_LIMIT, default 4096: maximum CTRL polls per transfer before timeout.
REQ-002 Parameter RX_ADDR, default 5'h00: address of the RX0 register.
REQ-003 wb_clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_in  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_data  input  32  TX0 payload.
REQ-008 cmd_len  input  7  char_len field (0 = 128 bits).
REQ-009 cmd_mode  input  3  {lsb, tx_neg, rx_neg}.
REQ-010 cmd_ss  input  32  slave-select mask.
REQ-011 cmd_div  input  16  SCLK divider value.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumed.
REQ-014 rsp_data  output  32  RX0 contents.
REQ-015 rsp_err  output  1  poll timeout occurred.
REQ-016 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master strobes toward spi_top.
REQ-017 wb_addr_o  output  5  register address; wb_sel_o  output  4  always 4'b1111 during an access.
REQ-018 wb_data_o  output  32  write data; wb_data_i  input  32  read data; wb_ack_i  input  1  access acknowledge.

Function
REQ-019 States SHALL be IDLE, WR_DIV, WR_SS, WR_TX, WR_CTRL, WR_GO, POLL, RD_RX, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is latched on cmd_valid&&cmd_ready.
REQ-021 Each access SHALL assert cyc=stb=1 with stable addr/data/we until the cycle wb_ack_i=1, then drop cyc/stb for at least one cycle before the next access.
REQ-022 Write sequence: DIVIDER (5'h14) <- cmd_div zero-extended; SS (5'h18) <- cmd_ss; TX0 (5'h00) <- cmd_data; CTRL (5'h10) <- ctrl word; CTRL <- ctrl word | bit8 (GO).
REQ-023 Ctrl word: [6:0]=cmd_len, bit9=rx_neg, bit10=tx_neg, bit11=lsb, bit12 (IE)=0, bit13 (ASS)=1, all other bits 0.
REQ-024 Config cache: WR_DIV SHALL be skipped when cache is valid and cmd_div equals the cached value; WR_SS likewise for cmd_ss; the cache updates when each write is acknowledged.
REQ-025 POLL: read CTRL; if bit8 is clear, go to RD_RX, else re-poll; a poll counter SHALL increment per acknowledged read.
REQ-026 When the counter reaches POLL_LIMIT with GO still set: go to RESP with rsp_err=1, rsp_data=0, and invalidate the cache.
REQ-027 RD_RX: read RX_ADDR; latch wb_data_i into rsp_data on ack; rsp_err=0.
REQ-028 RESP: rsp_valid=1 with rsp_data/rsp_err held stable until rsp_ready=1; return to IDLE the next cycle; rsp_valid and cmd_ready SHALL never be 1 together.
REQ-029 wb_ack_i outside an active access SHALL be ignored; an ack wait has no timeout.

Reset
REQ-030 On wb_rst_in=1 at a clock edge: state=IDLE; cyc/stb/we=0; addr/data_o=0; sel=0; rsp_valid=0; rsp_data=0; rsp_err=0; poll counter=0; cache invalid.
REQ-031 Reset mid-access SHALL drop cyc/stb in the same edge; the in-flight command is discarded and no response is issued.

Structure
REQ-032 Shared package spi_seq_pkg SHALL hold register addresses (TX0/RX0=5'h00, CTRL=5'h10, DIVIDER=5'h14, SS=5'h18), CTRL bit positions, and the state enumeration.
REQ-033 One sub-module, spi_seq_wb_access, SHALL implement the single read/write Wishbone access with a start/done handshake; the FSM sequences it.

Verification
REQ-034 Bench with spi_top and spi_slave: cmd len=4, mode lsb=1/tx_neg=0/rx_neg=1, div=4, ss=1, data=0x2361 -> writes 0x4, 0x1, 0x2361, 0x2A04, 0x2B04 in order; rsp_data equals the slave's returned nibble; rsp_err=0.
REQ-035 A second command with the same div/ss -> no DIVIDER or SS writes; first access is TX0.
REQ-036 A third command with ss=2 -> SS write only, DIVIDER skipped.
REQ-037 Stub slave holding CTRL bit8=1, POLL_LIMIT=8 -> exactly 8 CTRL reads, rsp_err=1, rsp_data=0; the next command rewrites DIVIDER and SS.
REQ-038 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-039 Reset asserted during the WR_TX ack wait -> cyc/stb=0 after that edge, no rsp_valid, cmd_ready=1 the next cycle.
